sum_of_squares_seq: RTL and testbench
=====================================

# sum_of_squares_seq

Sequential front-end of the vector-magnitude datapath: accepts an (x, y) operand pair over a valid/ready handshake, computes x² + y² with a bit-serial shift-add squarer, and presents the full-precision sum to the downstream integer square-root stage over a second valid/ready handshake. It replaces ad-hoc repeated-addition multiplication with a fixed, data-independent latency. The block holds at most one transaction in flight.

## Interface
- `WIDTH`, default 8: operand width in bits; the sum is `2*WIDTH+1` bits.
- `clk`  in  1  single rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `x_in`  in  WIDTH  x operand; sampled on the accept edge.
- `y_in`  in  WIDTH  y operand; sampled on the accept edge.
- `in_valid`  in  1  upstream offers an operand pair.
- `in_ready`  out  1  block can accept; high only in IDLE.
- `sum_out`  out  2*WIDTH+1  x² + y²; stable while `out_valid` is high.
- `out_valid`  out  1  result available; held until consumed.
- `out_ready`  in  1  downstream sqrt stage accepts the result.
- `busy`  out  1  high in every state except IDLE.

## Operation
- States: IDLE, SQ_X, SQ_Y, DONE.
- IDLE: `in_ready`=1. On `in_valid && in_ready`: capture both operands into internal registers, clear the accumulator, set bit index = 0, and go to SQ_X.
- SQ_X: each cycle, if captured x bit[idx] is 1, add `x << idx` to the accumulator. idx increments. After bit WIDTH-1, reset idx to 0 and go to SQ_Y.
- SQ_Y: same as SQ_X using y. After bit WIDTH-1, load `sum_out` with the final accumulator and go to DONE.
- DONE: `out_valid`=1. On `out_ready`, go to IDLE. Do not accept a new pair in the same cycle.
- Arithmetic:
  - The accumulator is 2*WIDTH+1 bits, unsigned, and never overflows; the worst case is 2·(2^WIDTH−1)².
  - Partial products are zero-extended before addition.
- Input changes outside the accept edge have no effect.
- `in_valid` is ignored while not in IDLE. Upstream must hold the pair until accepted.
- `out_ready` is ignored outside DONE.

## Timing
- Reset values: state=IDLE, `sum_out`=0, `out_valid`=0, `busy`=0, accumulator and idx cleared. `in_ready`=1 during and after reset, because it is decoded from IDLE.
- Reset mid-operation aborts the transaction immediately. No partial result is ever presented.
- Latency: for accept edge E0, `out_valid` rises after edge E0+2·WIDTH (16 cycles for WIDTH=8).
- `out_valid` drops on the edge where `out_ready` is sampled high in DONE.
- `in_ready` is high again from the following cycle.
- Throughput: one pair per 2·WIDTH+2 cycles when the sink is always ready.
- Backpressure: DONE may persist indefinitely. `sum_out` must not change while waiting.

## Configuration
- `SOS_SIGNED_IN_EN`
  - Defined: `x_in` and `y_in` are two's complement. The absolute value is taken at capture, and the magnitude is held in WIDTH unsigned bits, so −2^(WIDTH−1) becomes 2^(WIDTH−1). Results are otherwise identical.
  - Undefined: operands are unsigned and captured as-is.

## Structure
- Shared package `sos_pkg` contains:
  - state enum `sos_state_t` (IDLE, SQ_X, SQ_Y, DONE);
  - default `SOS_WIDTH`=8;
  - derived constant `SOS_SUM_W` = 2·WIDTH+1.
- One sub-module, `serial_sq_step`: combinational single-bit shift-add step. Inputs are operand, idx, and accumulator; output is the next accumulator. It is instantiated once and shared by SQ_X and SQ_Y via an operand mux.
- FSM, capture registers, and handshake logic live in the top module.

## Test plan
- Reset, then x=3, y=4, out_ready=1 → `sum_out`=25 with `out_valid` exactly 16 cycles after accept; `in_ready`=0 throughout.
- x=255, y=255 → `sum_out`=130050, checking that bit 16 is set and there is no overflow.
- x=0, y=0 → `sum_out`=0 after the same 16-cycle latency.
- Hold out_ready=0 for 40 cycles after a result (x=12, y=5 → 169) → `sum_out`/`out_valid` stable, `in_valid` pulses ignored, and the next pair accepted only after out_ready.
- Assert rst during SQ_Y → all outputs return to reset values; the next pair x=1, y=1 yields 2 with no residue.
- With `SOS_SIGNED_IN_EN`: x=8'h80 (−128), y=8'hFD (−3) → `sum_out`=16393.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared types and constants for the sum-of-squares front-end.
package sos_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ_X = 2'd1,
    SQ_Y = 2'd2,
    DONE = 2'd3
  } sos_state_t;

  localparam int unsigned SOS_WIDTH = 8;

  function automatic int unsigned sos_sum_w(input int unsigned w);
    return 2 * w + 1;
  endfunction

  localparam int unsigned SOS_SUM_W = sos_sum_w(SOS_WIDTH);

endpackage

// File: rtl/serial_sq_step.sv
// Single shift-add squaring step: adds (operand << idx) when operand[idx] is set.
module serial_sq_step #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SUM_W = 17,
  parameter int unsigned IDX_W = 3
) (
  input  logic [WIDTH-1:0] operand,
  input  logic [IDX_W-1:0] idx,
  input  logic [SUM_W-1:0] acc,
  output logic [SUM_W-1:0] acc_next
);

  logic [SUM_W-1:0] partial;

  always_comb begin
    partial  = {{(SUM_W-WIDTH){1'b0}}, operand} << idx;
    acc_next = acc;
    if (operand[idx]) acc_next = acc + partial;
  end

endmodule

// File: rtl/sum_of_squares_seq.sv
// Bit-serial x^2 + y^2 with valid/ready handshakes on both sides.
// Optional SOS_SIGNED_IN_EN: operands are two's complement, magnitude taken at capture.
module sum_of_squares_seq
  import sos_pkg::*;
#(
  parameter int unsigned WIDTH = SOS_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] y_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [2*WIDTH:0] sum_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned SUM_W = sos_sum_w(WIDTH);
  localparam int unsigned IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  sos_state_t       state, state_next;
  logic [WIDTH-1:0] x_q, y_q, x_cap, y_cap, op;
  logic [IDX_W-1:0] idx;
  logic [SUM_W-1:0] acc, acc_next;
  logic             last_bit;

  assign last_bit = (idx == IDX_W'(WIDTH - 1));

`ifdef SOS_SIGNED_IN_EN
  // Magnitude of the most negative value wraps to 2^(WIDTH-1), which fits unsigned.
  assign x_cap = x_in[WIDTH-1] ? (~x_in + WIDTH'(1)) : x_in;
  assign y_cap = y_in[WIDTH-1] ? (~y_in + WIDTH'(1)) : y_in;
`else
  assign x_cap = x_in;
  assign y_cap = y_in;
`endif

  assign op = (state == SQ_Y) ? y_q : x_q;

  serial_sq_step #(
    .WIDTH (WIDTH),
    .SUM_W (SUM_W),
    .IDX_W (IDX_W)
  ) u_step (
    .operand  (op),
    .idx      (idx),
    .acc      (acc),
    .acc_next (acc_next)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = SQ_X;
      SQ_X:    if (last_bit)  state_next = SQ_Y;
      SQ_Y:    if (last_bit)  state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    busy      = (state != IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      acc     <= '0;
      idx     <= '0;
      sum_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x_q <= x_cap;
            y_q <= y_cap;
            acc <= '0;
            idx <= '0;
          end
        end
        SQ_X, SQ_Y: begin
          acc <= acc_next;
          idx <= last_bit ? '0 : idx + IDX_W'(1);
          if (state == SQ_Y && last_bit) sum_out <= acc_next;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_of_squares_seq.sv
// Randomized self-checking bench for sum_of_squares_seq against an arithmetic model.
module tb_sum_of_squares_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] x_in, y_in;
  logic         in_valid, in_ready;
  logic [2*W:0] sum_out;
  logic         out_valid, out_ready, busy;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sum_of_squares_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .x_in      (x_in),
    .y_in      (y_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sum_out   (sum_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy)
  );

  function automatic longint unsigned model(input logic [W-1:0] x, input logic [W-1:0] y);
    longint xv, yv;
`ifdef SOS_SIGNED_IN_EN
    xv = longint'($signed(x));
    yv = longint'($signed(y));
    if (xv < 0) xv = -xv;
    if (yv < 0) yv = -yv;
`else
    xv = longint'(x);
    yv = longint'(y);
`endif
    return longint'(xv * xv + yv * yv);
  endfunction

  task automatic check_eq(input string tag, input longint unsigned got, input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic do_pair(input logic [W-1:0] x, input logic [W-1:0] y,
                         input longint unsigned exp, input int stall);
    int cyc;
    bit seen;
    @(negedge clk);
    check_eq("in_ready_idle", in_ready, 1);
    x_in      = x;
    y_in      = y;
    in_valid  = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x_in     = W'($urandom);
    y_in     = W'($urandom);
    check_eq("busy_after_accept", busy, 1);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (out_valid) seen = 1'b1;
      else           check_eq("in_ready_low_busy", in_ready, 0);
    end
    check_eq("latency", cyc, 16);
    check_eq("sum", sum_out, exp);
    if (stall > 0) begin
      repeat (stall) begin
        in_valid = 1'($urandom);
        x_in     = W'($urandom);
        y_in     = W'($urandom);
        @(posedge clk);
        #1;
        check_eq("hold_sum", sum_out, exp);
        check_eq("hold_valid", out_valid, 1);
        check_eq("hold_in_ready", in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
    end
    @(posedge clk);
    #1;
    check_eq("valid_drop", out_valid, 0);
    check_eq("in_ready_back", in_ready, 1);
    check_eq("busy_drop", busy, 0);
  endtask

  initial begin
    logic [W-1:0] rx, ry;
    rst       = 1'b1;
    x_in      = '0;
    y_in      = '0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_sum", sum_out, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    do_pair(8'd3, 8'd4, model(8'd3, 8'd4), 0);
`ifdef SOS_SIGNED_IN_EN
    do_pair(8'h80, 8'hFD, 64'd16393, 0);
    do_pair(8'd12, 8'd5, 64'd169, 40);
`else
    do_pair(8'd3, 8'd4, 64'd25, 0);
    do_pair(8'd255, 8'd255, 64'd130050, 0);
    check_eq("bit16_set", sum_out[16], 1);
    do_pair(8'd0, 8'd0, 64'd0, 0);
    do_pair(8'd12, 8'd5, 64'd169, 40);
`endif

    // Abort mid-SQ_Y with reset.
    @(negedge clk);
    x_in     = 8'd7;
    y_in     = 8'd9;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    #1;
    check_eq("busy_before_abort", busy, 1);
    rst = 1'b1;
    #1;
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_sum", sum_out, 0);
    @(negedge clk);
    rst = 1'b0;
    do_pair(8'd1, 8'd1, 64'd2, 0);

    for (int i = 0; i < 20; i++) begin
      rx = W'($urandom);
      ry = W'($urandom);
      do_pair(rx, ry, model(rx, ry), int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
